calc_rr_multiport: RTL and testbench

//   Parametrised multi-port calculator, successor to the fixed 4-port calc1 engine.
//   NUM_PORTS requesters share one ALU through per-port request FIFOs and a round-robin arbiter.
//   The block adds subtract, shift-left and shift-right, plus a queue-full reject response.
//   It sits between the requester ports and the response bus.

---
 rtl/calc_rr_multiport.sv | 245 ++++++++++++++++++++++++
 tb/tb_calc_rr_multiport.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_rr_multiport.sv
// Multi-port calculator: per-port two-cycle operand capture into small FIFOs,
// a round-robin arbiter feeding one ALU, and a registered per-port response bus.

module calc_rr_port #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [3:0]        hd_cmd,
    output logic [DATA_W-1:0] hd_op1,
    output logic [DATA_W-1:0] hd_op2,
    output logic              empty,
    output logic              rej_pend
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {ST_IDLE, ST_OP2} st_e;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    st_e                    st_q, st_d;
    logic [3:0]             cmd_q, cmd_d;
    logic [DATA_W-1:0]      op1_q, op1_d;
    req_t [FIFO_DEPTH-1:0]  mem_q, mem_d;
    logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   rej_q, rej_d;
    logic                   push_req, push_ok, do_pop, full;

    always_comb begin
        st_d   = st_q;
        cmd_d  = cmd_q;
        op1_d  = op1_q;
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;

        // fullness is judged before this cycle's pop, so a full FIFO rejects even while draining
        full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
        push_req = (st_q == ST_OP2);
        push_ok  = push_req && !full;
        do_pop   = pop && (cnt_q != '0);
        rej_d    = push_req && full;

        case (st_q)
            ST_IDLE: begin
                if (cmd_in != 4'd0) begin
                    st_d  = ST_OP2;
                    cmd_d = cmd_in;
                    op1_d = data_in;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        if (push_ok) begin
            mem_d[wr_q].cmd = cmd_q;
            mem_d[wr_q].op1 = op1_q;
            mem_d[wr_q].op2 = data_in;
            wr_d = wr_q + AW'(1);
        end
        if (do_pop) rd_d = rd_q + AW'(1);

        case ({push_ok, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            st_q  <= ST_IDLE;
            cmd_q <= '0;
            op1_q <= '0;
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            rej_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cmd_q <= cmd_d;
            op1_q <= op1_d;
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            rej_q <= rej_d;
        end
    end

    assign hd_cmd   = mem_q[rd_q].cmd;
    assign hd_op1   = mem_q[rd_q].op1;
    assign hd_op2   = mem_q[rd_q].op2;
    assign empty    = (cnt_q == '0);
    assign rej_pend = rej_q;
endmodule

module calc_rr_multiport #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*2-1:0]      out_resp
);
    localparam int PW  = $clog2(NUM_PORTS);
    localparam int SHW = $clog2(DATA_W);

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;
    localparam logic [1:0] RESP_REJ = 2'd3;

    logic [NUM_PORTS-1:0][3:0]        hd_cmd;
    logic [NUM_PORTS-1:0][DATA_W-1:0] hd_op1, hd_op2;
    logic [NUM_PORTS-1:0]             empty, rej_pend, pop, elig;

    logic [PW-1:0]                    ptr_q, ptr_d, grant_idx;
    logic                             grant_vld;
    int                               arb_idx;

    logic [3:0]                       g_cmd;
    logic [DATA_W-1:0]                g_op1, g_op2, alu_data;
    logic [DATA_W:0]                  sum_ext;
    logic [1:0]                       alu_resp;

    logic [NUM_PORTS-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        calc_rr_port #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_port (
            .c_clk    (c_clk),
            .reset    (reset),
            .cmd_in   (req_cmd_in[g*4 +: 4]),
            .data_in  (req_data_in[g*DATA_W +: DATA_W]),
            .pop      (pop[g]),
            .hd_cmd   (hd_cmd[g]),
            .hd_op1   (hd_op1[g]),
            .hd_op2   (hd_op2[g]),
            .empty    (empty[g]),
            .rej_pend (rej_pend[g])
        );
    end

    // a port whose push just bounced is owed its reject slot this cycle, so it sits out arbitration
    always_comb begin
        elig      = ~empty & ~rej_pend;
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        pop       = '0;
        ptr_d     = ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
            if (!grant_vld && elig[arb_idx]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(arb_idx);
            end
        end
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
            ptr_d = (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_comb begin
        g_cmd    = hd_cmd[grant_idx];
        g_op1    = hd_op1[grant_idx];
        g_op2    = hd_op2[grant_idx];
        sum_ext  = {1'b0, g_op1} + {1'b0, g_op2};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (g_cmd)
            4'd1: begin
                if (!sum_ext[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum_ext[DATA_W-1:0];
                end
            end
            4'd2: begin
                if (g_op1 >= g_op2) begin
                    alu_resp = RESP_OK;
                    alu_data = g_op1 - g_op2;
                end
            end
            4'd5: begin
                alu_resp = RESP_OK;
                alu_data = g_op1 << g_op2[SHW-1:0];
            end
            4'd6: begin
                alu_resp = RESP_OK;
                alu_data = g_op1 >> g_op2[SHW-1:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    always_comb begin
        resp_d = '0;
        data_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rej_pend[p]) resp_d[p] = RESP_REJ;
        end
        if (grant_vld) begin
            resp_d[grant_idx] = alu_resp;
            data_d[grant_idx] = alu_data;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            ptr_q  <= '0;
            resp_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            resp_q <= resp_d;
            data_q <= data_d;
        end
    end

    assign out_data = data_q;
    assign out_resp = resp_q;
endmodule

// File: tb/tb_calc_rr_multiport.sv
// Directed bench for calc_rr_multiport: latency, ALU corner cases, round-robin order,
// overload rejects and mid-flight reset, each scenario in its own task.

module tb_calc_rr_multiport;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int FD = 2;

    logic             c_clk = 1'b0;
    logic             reset;
    logic [NP*4-1:0]  req_cmd_in;
    logic [NP*DW-1:0] req_data_in;
    logic [NP*DW-1:0] out_data;
    logic [NP*2-1:0]  out_resp;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 c_clk = ~c_clk;

    calc_rr_multiport #(
        .NUM_PORTS  (NP),
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_data    (out_data),
        .out_resp    (out_resp)
    );

    task automatic nclk();
        @(negedge c_clk);
    endtask

    task automatic drive_idle();
        req_cmd_in  = '0;
        req_data_in = '0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_cmd_in  = {NP{4'd1}};
        req_data_in = '1;
        for (int i = 0; i < 3; i++) begin
            nclk();
            tests_run++;
            if (out_resp !== '0) begin
                tests_failed++;
                $display("FAIL reset_resp[%0d]: got %0h expected 0", i, out_resp);
            end
            tests_run++;
            if (out_data !== '0) begin
                tests_failed++;
                $display("FAIL reset_data[%0d]: got %0h expected 0", i, out_data);
            end
        end
        reset = 1'b0;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            nclk();
            tests_run++;
            if (out_resp !== '0) begin
                tests_failed++;
                $display("FAIL post_reset_quiet[%0d]: got %0h expected 0", i, out_resp);
            end
        end
    endtask

    task automatic test_latency();
        req_cmd_in[3:0]   = 4'd1;
        req_data_in[31:0] = 32'h0000_0001;
        nclk();
        req_cmd_in[3:0]   = 4'd0;
        req_data_in[31:0] = 32'h1FFF_FFFF;
        nclk();
        drive_idle();
        tests_run++;
        if (out_resp !== '0) begin
            tests_failed++;
            $display("FAIL lat_early: got %0h expected 0", out_resp);
        end
        nclk();
        tests_run++;
        if (out_resp[1:0] !== 2'd1) begin
            tests_failed++;
            $display("FAIL lat_resp: got %0d expected 1", out_resp[1:0]);
        end
        tests_run++;
        if (out_data[31:0] !== 32'h2000_0000) begin
            tests_failed++;
            $display("FAIL lat_data: got %0h expected 20000000", out_data[31:0]);
        end
        nclk();
        tests_run++;
        if (out_resp !== '0 || out_data !== '0) begin
            tests_failed++;
            $display("FAIL lat_one_cycle: got resp %0h data %0h expected 0", out_resp, out_data);
        end
    endtask

    task automatic test_alu();
        int          tp [6] = '{2, 1, 1, 3, 3, 3};
        logic [3:0]  tc [6] = '{4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd9};
        logic [31:0] t1 [6] = '{32'h8000_0000, 32'd5, 32'd7, 32'd1, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] t2 [6] = '{32'h8000_0000, 32'd7, 32'd5, 32'd31, 32'd35, 32'd1};
        logic [1:0]  tr [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2};
        logic [31:0] td [6] = '{32'd0, 32'd0, 32'd2, 32'h8000_0000, 32'h1000_0000, 32'd0};
        logic [NP*2-1:0] exp_resp;
        for (int i = 0; i < 6; i++) begin
            req_cmd_in[tp[i]*4 +: 4]    = tc[i];
            req_data_in[tp[i]*DW +: DW] = t1[i];
            nclk();
            req_cmd_in[tp[i]*4 +: 4]    = 4'd0;
            req_data_in[tp[i]*DW +: DW] = t2[i];
            nclk();
            drive_idle();
            nclk();
            exp_resp = '0;
            exp_resp[tp[i]*2 +: 2] = tr[i];
            tests_run++;
            if (out_resp !== exp_resp) begin
                tests_failed++;
                $display("FAIL alu_resp[%0d]: got %0h expected %0h", i, out_resp, exp_resp);
            end
            tests_run++;
            if (out_data[tp[i]*DW +: DW] !== td[i]) begin
                tests_failed++;
                $display("FAIL alu_data[%0d]: got %0h expected %0h", i, out_data[tp[i]*DW +: DW], td[i]);
            end
            nclk();
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        drive_idle();
        nclk();
        reset = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < NP; p++) begin
                req_cmd_in[p*4 +: 4]    = 4'd1;
                req_data_in[p*DW +: DW] = DW'(p + 1);
            end
            nclk();
            drive_idle();
            nclk();
            nclk();
            for (int k = 0; k < NP; k++) begin
                for (int q = 0; q < NP; q++) begin
                    tests_run++;
                    if (out_resp[q*2 +: 2] !== ((q == k) ? 2'd1 : 2'd0)) begin
                        tests_failed++;
                        $display("FAIL rr_resp b%0d c%0d p%0d: got %0d expected %0d",
                                 b, k, q, out_resp[q*2 +: 2], (q == k) ? 1 : 0);
                    end
                    tests_run++;
                    if (out_data[q*DW +: DW] !== ((q == k) ? DW'(k + 1) : '0)) begin
                        tests_failed++;
                        $display("FAIL rr_data b%0d c%0d p%0d: got %0h expected %0h",
                                 b, k, q, out_data[q*DW +: DW], (q == k) ? k + 1 : 0);
                    end
                end
                nclk();
            end
        end
    endtask

    task automatic test_back_to_back();
        int          issued [NP];
        int          got    [NP];
        int          rej    [NP];
        logic [31:0] last   [NP];
        logic [1:0]  r;
        logic [31:0] d;
        for (int p = 0; p < NP; p++) begin
            issued[p] = 0;
            got[p]    = 0;
            rej[p]    = 0;
            last[p]   = '0;
        end
        for (int c = 0; c < 48; c++) begin
            for (int p = 0; p < NP; p++) begin
                r = out_resp[p*2 +: 2];
                d = out_data[p*DW +: DW];
                if (r != 2'd0) got[p]++;
                if (r == 2'd3) begin
                    rej[p]++;
                    tests_run++;
                    if (d !== '0) begin
                        tests_failed++;
                        $display("FAIL b2b_rej_data p%0d c%0d: got %0h expected 0", p, c, d);
                    end
                end else if (r == 2'd1) begin
                    tests_run++;
                    if (!(d > last[p] && (d >> 8) == 32'(p))) begin
                        tests_failed++;
                        $display("FAIL b2b_order p%0d c%0d: got %0h expected tag of port %0d above %0h",
                                 p, c, d, p, last[p]);
                    end
                    last[p] = d;
                end else if (r == 2'd2) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL b2b_resp p%0d c%0d: got 2 expected 1 or 3", p, c);
                end
            end
            if (c < 16 && (c % 2) == 0) begin
                for (int p = 0; p < NP; p++) begin
                    req_cmd_in[p*4 +: 4]    = 4'd1;
                    req_data_in[p*DW +: DW] = (32'(p) << 8) | 32'(c / 2 + 1);
                    issued[p]++;
                end
            end else begin
                drive_idle();
            end
            nclk();
        end
        for (int p = 0; p < NP; p++) begin
            tests_run++;
            if (got[p] !== issued[p]) begin
                tests_failed++;
                $display("FAIL b2b_count p%0d: got %0d expected %0d", p, got[p], issued[p]);
            end
            tests_run++;
            if (rej[p] < 1) begin
                tests_failed++;
                $display("FAIL b2b_reject p%0d: got %0d rejects expected at least 1", p, rej[p]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        req_cmd_in[3:0]   = 4'd1;
        req_data_in[31:0] = 32'h11;
        nclk();
        req_cmd_in[3:0]   = 4'd0;
        req_data_in[31:0] = 32'h22;
        nclk();
        drive_idle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nclk();
            tests_run++;
            if (out_resp !== '0 || out_data !== '0) begin
                tests_failed++;
                $display("FAIL midrst_quiet[%0d]: got resp %0h data %0h expected 0", i, out_resp, out_data);
            end
        end
        reset = 1'b0;
        req_cmd_in[3:0]   = 4'd1;
        req_data_in[31:0] = 32'd3;
        nclk();
        req_cmd_in[3:0]   = 4'd0;
        req_data_in[31:0] = 32'd4;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (out_resp !== '0) begin
                tests_failed++;
                $display("FAIL midrst_stale[%0d]: got %0h expected 0", i, out_resp);
            end
            nclk();
            drive_idle();
        end
        tests_run++;
        if (out_resp !== 8'h01) begin
            tests_failed++;
            $display("FAIL midrst_resp: got %0h expected 01", out_resp);
        end
        tests_run++;
        if (out_data[31:0] !== 32'd7) begin
            tests_failed++;
            $display("FAIL midrst_data: got %0h expected 7", out_data[31:0]);
        end
        nclk();
        tests_run++;
        if (out_resp !== '0) begin
            tests_failed++;
            $display("FAIL midrst_after: got %0h expected 0", out_resp);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_latency();
        test_alu();
        test_round_robin();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
